// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// Optional build macro HILO_MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module hilo_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  cancel,
    input  logic                  we_hi,
    input  logic                  we_lo,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  stall_req,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    hi, lo;
    logic [W-1:0]    mag_b, quot, rem;
    logic [2*W-1:0]  prod;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r, dbz;

    logic            is_signed, a_neg, b_neg, accept, b_zero, last;
    logic [W-1:0]    in_mag_a, in_mag_b;
    logic [W:0]      r_shift, r_diff;
    logic [W-1:0]    quot_step, rem_step, quot_final, rem_final;
    logic [2*W-1:0]  prod_final, prod_signed;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & src_a[W-1];
    assign b_neg     = is_signed & src_b[W-1];
    assign in_mag_a  = a_neg ? -src_a : src_a;
    assign in_mag_b  = b_neg ? -src_b : src_b;
    assign accept    = start & ~cancel;
    assign b_zero    = (src_b == '0);
    assign last      = (cnt == CW'(W - 1));

    // Restoring division step: the remainder never exceeds the divisor, so W bits suffice.
    assign r_shift    = {rem, quot[W-1]};
    assign r_diff     = r_shift - {1'b0, mag_b};
    assign quot_step  = {quot[W-2:0], ~r_diff[W]};
    assign rem_step   = r_diff[W] ? r_shift[W-1:0] : r_diff[W-1:0];
    assign quot_final = neg_q ? -quot_step : quot_step;
    assign rem_final  = neg_r ? -rem_step : rem_step;

`ifdef HILO_MULDIV_FAST_MUL_EN
    assign prod_final = prod;
`else
    logic [W-1:0]   mag_a;
    logic [W:0]     m_sum;
    logic [2*W-1:0] prod_step;

    // Shift-add: the multiplier sits in the low half and is consumed LSB first.
    assign m_sum      = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mag_a} : '0);
    assign prod_step  = {m_sum, prod[W-1:1]};
    assign prod_final = prod_step;
`endif
    assign prod_signed = neg_q ? -prod_final : prod_final;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = op[1] ? (b_zero ? DONE : DIV) : MUL;
`ifdef HILO_MULDIV_FAST_MUL_EN
            MUL:  state_next = cancel ? IDLE : DONE;
`else
            MUL:  if (cancel) state_next = IDLE; else if (last) state_next = DONE;
`endif
            DIV:  if (cancel) state_next = IDLE; else if (last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // MTHI/MTLO land first so that a result committed on the same edge overrides them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            mag_b <= '0;
            quot  <= '0;
            rem   <= '0;
            prod  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz   <= 1'b0;
`ifndef HILO_MULDIV_FAST_MUL_EN
            mag_a <= '0;
`endif
        end else begin
            if (we_hi) hi <= wdata;
            if (we_lo) lo <= wdata;
            case (state)
                IDLE: if (accept) begin
                    mag_b <= in_mag_b;
                    quot  <= in_mag_a;
                    rem   <= '0;
                    cnt   <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    dbz   <= op[1] & b_zero;
`ifdef HILO_MULDIV_FAST_MUL_EN
                    prod  <= (2*W)'(in_mag_a) * (2*W)'(in_mag_b);
`else
                    mag_a <= in_mag_a;
                    prod  <= {{W{1'b0}}, in_mag_b};
`endif
                end
                MUL: if (!cancel) begin
`ifdef HILO_MULDIV_FAST_MUL_EN
                    {hi, lo} <= prod_signed;
`else
                    prod <= prod_step;
                    cnt  <= cnt + 1'b1;
                    if (last) {hi, lo} <= prod_signed;
`endif
                end
                DIV: if (!cancel) begin
                    quot <= quot_step;
                    rem  <= rem_step;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        hi <= rem_final;
                        lo <= quot_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign div_by_zero = done & dbz;
    assign stall_req   = (start & (state == IDLE)) | (busy & ~done);
    assign hi_out      = hi;
    assign lo_out      = lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed corner cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam int W = 32;
`ifdef HILO_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
    localparam bit FAST    = 1'b1;
`else
    localparam int MUL_LAT = W + 1;
    localparam bit FAST    = 1'b0;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, cancel = 1'b0, we_hi = 1'b0, we_lo = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0, src_b = '0, wdata = '0;
    logic         busy, stall_req, done, div_by_zero;
    logic [W-1:0] hi_out, lo_out;

    hilo_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy(busy), .stall_req(stall_req), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] model_hi = '0, model_lo = '0;
    int           cycle = 0;
    int           tests_run = 0, tests_failed = 0;
    logic         stall_at_start;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: HI/LO after an operation, from signed/unsigned arithmetic rules.
    function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] rhi, output logic [W-1:0] rlo, output logic rdbz);
        logic signed [63:0] sa, sbv, sq, sr;
        logic [63:0]        p;
        sa   = $signed(a);
        sbv  = $signed(b);
        rhi  = model_hi;
        rlo  = model_lo;
        rdbz = 1'b0;
        case (o)
            2'b00: begin p = sa * sbv; {rhi, rlo} = p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; {rhi, rlo} = p; end
            2'b10: if (b == 0) rdbz = 1'b1;
                   else begin sq = sa / sbv; sr = sa % sbv; rlo = sq[W-1:0]; rhi = sr[W-1:0]; end
            default: if (b == 0) rdbz = 1'b1;
                     else begin rlo = a / b; rhi = a % b; end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) checkOutput("unexpected_done", 1, 0);
            else begin
                mon_e = sb_q.pop_front();
                checkOutput("sb_hi", hi_out, mon_e.hi);
                checkOutput("sb_lo", lo_out, mon_e.lo);
                checkOutput("sb_dbz", div_by_zero, mon_e.dbz);
                checkOutput("sb_latency_cycle", cycle, mon_e.cyc);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit expect_result);
        exp_t e;
        int   lat;
        @(negedge clk);
        if (expect_result) begin
            ref_model(o, a, b, e.hi, e.lo, e.dbz);
            lat   = o[1] ? ((b == 0) ? 1 : DIV_LAT) : MUL_LAT;
            e.cyc = cycle + lat;
            sb_q.push_back(e);
            if (!e.dbz) begin
                model_hi = e.hi;
                model_lo = e.lo;
            end
        end
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1 stall_at_start = stall_req;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("wait_idle_timeout", 1, 0);
    endtask

    task automatic writeHiLo(input bit h, input bit l, input logic [W-1:0] d);
        @(negedge clk);
        we_hi = h; we_lo = l; wdata = d;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        if (h) model_hi = d;
        if (l) model_lo = d;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bad;
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_dbz", div_by_zero, 0);
        checkOutput("reset_stall", stall_req, 0);
        checkOutput("reset_hi", hi_out, 0);
        checkOutput("reset_lo", lo_out, 0);

        // MULT -2 * 3 with stall_req tracking over the whole operation.
        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3, 1);
        checkOutput("t1_stall_at_start", stall_at_start, 1);
        bad = 0;
        while (busy && bad < 1000) begin
            if (!done && !stall_req) bad++;
            if (done && stall_req) bad++;
            @(negedge clk);
        end
        checkOutput("t1_stall_profile", bad, 0);
        checkOutput("t1_hi", hi_out, 32'hFFFF_FFFF);
        checkOutput("t1_lo", lo_out, 32'hFFFF_FFFA);

        applyStimulus(2'b10, -32'sd7, 32'd2, 1); waitIdle();
        checkOutput("t2_div_lo", lo_out, 32'hFFFF_FFFD);
        checkOutput("t2_div_hi", hi_out, 32'hFFFF_FFFF);
        applyStimulus(2'b11, 32'd7, 32'd2, 1); waitIdle();
        checkOutput("t2_divu_lo", lo_out, 32'd3);
        checkOutput("t2_divu_hi", hi_out, 32'd1);

        writeHiLo(1, 0, 32'h11);
        writeHiLo(0, 1, 32'h22);
        applyStimulus(2'b11, 32'd5, 32'd0, 1); waitIdle();
        checkOutput("t3_hi_kept", hi_out, 32'h11);
        checkOutput("t3_lo_kept", lo_out, 32'h22);

        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1); waitIdle();
        checkOutput("t4_lo", lo_out, 32'h8000_0000);
        checkOutput("t4_hi", hi_out, 32'h0);

        // Cancel mid-division: no done pulse, HI/LO keep old values.
        applyStimulus(2'b10, 32'd1000, 32'd3, 0);
        repeat (8) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkOutput("t5_cancel_busy", busy, 0);
        repeat (40) @(negedge clk);
        checkOutput("t5_cancel_hi", hi_out, model_hi);
        checkOutput("t5_cancel_lo", lo_out, model_lo);

        applyStimulus(2'b10, 32'd1000, 32'd3, 0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0; model_lo = '0;
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_hi", hi_out, 0);
        checkOutput("t5_rst_lo", lo_out, 0);
        repeat (40) @(negedge clk);

        writeHiLo(0, 1, 32'hABCD);
        checkOutput("t6_mtlo", lo_out, 32'hABCD);
        applyStimulus(2'b01, 32'd2, 32'd3, 1);
        we_hi = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        we_hi = 1'b0;
        checkOutput("t6_mthi_busy", hi_out, FAST ? 32'h0 : 32'h5555);
        waitIdle();
        checkOutput("t6_hi", hi_out, 32'h0);
        checkOutput("t6_lo", lo_out, 32'h6);

        // Start while busy is ignored; start with cancel in IDLE is ignored.
        applyStimulus(2'b11, 32'd100, 32'd7, 1);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        @(negedge clk);
        start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checkOutput("cancel_start_idle", busy, 0);

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = '0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_b = 32'($urandom_range(1, 15));
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) writeHiLo(1, 1, $urandom);
            applyStimulus(r_op, r_a, r_b, 1);
            waitIdle();
        end

        repeat (3) @(negedge clk);
        checkOutput("sb_leftover", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
